fuec_scrub_ctrl_13_8: RTL and testbench
=======================================

FUEC_SCRUB_CTRL_13_8 -- requirements
Module: fuec_scrub_ctrl_13_8

Interface
REQ-001 The block SHALL have parameters DEPTH (default 16, number of 13-bit memory words) and SCRUB_INTERVAL (default 256, idle cycles between scrub accesses).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state updates on the rising edge); rst_n input 1 (synchronous, active-low).
REQ-003 The block SHALL have the following host ports:
- host_req input 1: access request.
- host_we input 1: 1 = write, 0 = read.
- host_addr input ADDR_W: word address, ADDR_W = $clog2(DEPTH).
- host_wdata input 8: write data.
- host_gnt output 1: request accepted this cycle.
- host_rvalid output 1: host_rdata valid.
- host_rdata output 8: corrected read data.
- host_err output 1: uncorrectable error, qualified by host_rvalid.
REQ-004 The block SHALL have the following memory ports:
- mem_en output 1: memory access enable.
- mem_we output 1: write enable.
- mem_addr output ADDR_W: word address.
- mem_wdata output 13: codeword to store.
- mem_rdata input 13: codeword, valid the cycle after a read (mem_en=1, mem_we=0).
REQ-005 The block SHALL have the following status ports:
- scrub_en input 1: enables background scrubbing.
- corr_cnt output 16: corrected-error count.
- uncorr_cnt output 16: uncorrectable-error count.
- busy output 1: FSM not in IDLE.

Function
REQ-006 Codeword layout SHALL be cw[12:5] = data, cw[4:0] = parity; encoding and decoding use the existing fuec_encoder_13_8 and fuec_decoder_13_8 instances, both combinational.
REQ-007 The FSM SHALL have states IDLE, RD, DEC, WB and WR.
REQ-008 In IDLE with host_req=1, host_gnt SHALL be 1 combinationally, and the block SHALL capture host_we, host_addr and host_wdata. The next state SHALL be WR if host_we=1, else RD.
REQ-009 host_gnt SHALL be 0 in every state except IDLE; the host holds req, addr and data until granted.
REQ-010 In WR the block SHALL drive mem_en=1, mem_we=1, and mem_wdata = encoder cw of the captured data, then return to IDLE. A write SHALL take 2 cycles from grant.
REQ-011 In RD the block SHALL drive mem_en=1 and mem_we=0 at the captured address, then go to DEC.
REQ-012 In DEC the decoder input SHALL be mem_rdata.
- For a host read: host_rvalid=1, host_rdata = r_fix[12:5], host_err = uncorrectable. host_rvalid is asserted 2 cycles after grant.
REQ-013 In DEC, outcome handling SHALL be:
- corrected=1: corr_cnt increments and the next state is WB.
- uncorrectable=1: uncorr_cnt increments, no writeback, and the next state is IDLE.
- no_error=1: the next state is IDLE.
REQ-014 In WB the block SHALL drive mem_en=1, mem_we=1, mem_wdata = r_fix at the same address, then return to IDLE. The host is not granted during WB.
REQ-015 A scrub timer SHALL count cycles while scrub_en=1. On reaching SCRUB_INTERVAL-1 it sets scrub_pend and reloads 0.
- scrub_en=0 holds the timer and clears scrub_pend.
REQ-016 In IDLE with scrub_pend=1 and host_req=0, the block SHALL start a scrub: RD, then DEC, then optionally WB, at scrub_addr.
- scrub_pend clears on scrub start.
- scrub_addr increments after DEC and wraps from DEPTH-1 to 0.
- host_rvalid stays 0 for scrubs.
REQ-017 A host request in the same IDLE cycle as scrub_pend SHALL win. The scrub remains pending.
REQ-018 corr_cnt and uncorr_cnt SHALL saturate at 16'hFFFF.
REQ-019 mem_en SHALL be 0 in IDLE and DEC.

Reset
REQ-020 While rst_n=0 at a clock edge, the block SHALL:
- go to IDLE;
- clear host_gnt, host_rvalid, host_rdata, host_err, mem_en, mem_we, mem_addr, mem_wdata, corr_cnt, uncorr_cnt and busy to 0;
- clear timer, scrub_pend and scrub_addr to 0.
REQ-021 Reset asserted mid-operation (any state) SHALL abort the access with no further mem_en, including a pending WB.

Structure
REQ-022 A package fuec_13_8_pkg SHALL hold:
- the state enum;
- DATA_W=8, PAR_W=5, CW_W=13;
- DATA_MSB=12, DATA_LSB=5.
REQ-023 The scrub timer plus address counter SHALL be one natural sub-module, fuec_scrub_timer. The FSM, encoder and decoder instances live in the top.

Verification
REQ-024 Host write 0xAC to addr 3, then read addr 3 -> gnt pulses, write occurs grant+1, rvalid at grant+2 with rdata=0xAC, err=0, corr_cnt=0.
REQ-025 Flip one bit of stored word 3 in the memory model, then host read -> rdata=0xAC, corr_cnt=1, WB cycle writes the corrected codeword to addr 3.
REQ-026 Inject an uncorrectable pattern into addr 5, then read -> err=1 with rvalid, uncorr_cnt=1, no WB write.
REQ-027 SCRUB_INTERVAL=4, scrub_en=1, single-bit errors in all 16 words -> all corrected by writeback, corr_cnt=16, scrub_addr wraps to 0 after addr 15.
REQ-028 host_req asserted in the same cycle scrub_pend is set -> host granted first, scrub RD follows the host access.
REQ-029 rst_n=0 during WB -> no write issued that cycle, all outputs and counters 0 next cycle.

Source files
------------

// File: rtl/fuec_13_8_pkg.sv
// Shared widths, FSM state type and the Hamming check-bit function for the 13/8 SEC-DED scrubber.
package fuec_13_8_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PAR_W    = 5;
  localparam int unsigned CW_W     = 13;
  localparam int unsigned DATA_MSB = 12;
  localparam int unsigned DATA_LSB = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DEC,
    WB,
    WR
  } state_e;

  // Four Hamming check bits; data bit j uses H column 3,5,6,7,9,10,11,12 for j = 0..7.
  // cw[4] is the overall parity bit that turns SEC into SEC-DED.
  function automatic logic [PAR_W-2:0] hamming_chk(input logic [DATA_W-1:0] d);
    logic [PAR_W-2:0] c;
    c[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

endpackage

// File: rtl/fuec_decoder_13_8.sv
// Combinational SEC-DED decoder: corrects any single-bit error, flags double errors.
module fuec_decoder_13_8
  import fuec_13_8_pkg::*;
(
  input  logic [CW_W-1:0] r,
  output logic [CW_W-1:0] r_fix,
  output logic            no_error,
  output logic            corrected,
  output logic            uncorrectable
);

  logic [PAR_W-2:0] syn;
  logic             ovr;
  logic             pos_ok;
  logic [CW_W-1:0]  flip;

  // Syndrome to bit position; odd overall parity means a single (correctable) error.
  always_comb begin
    syn    = hamming_chk(r[DATA_MSB:DATA_LSB]) ^ r[PAR_W-2:0];
    ovr    = ^r;
    flip   = '0;
    pos_ok = 1'b1;
    case (syn)
      4'd0:    flip[4]  = 1'b1;
      4'd1:    flip[0]  = 1'b1;
      4'd2:    flip[1]  = 1'b1;
      4'd4:    flip[2]  = 1'b1;
      4'd8:    flip[3]  = 1'b1;
      4'd3:    flip[5]  = 1'b1;
      4'd5:    flip[6]  = 1'b1;
      4'd6:    flip[7]  = 1'b1;
      4'd7:    flip[8]  = 1'b1;
      4'd9:    flip[9]  = 1'b1;
      4'd10:   flip[10] = 1'b1;
      4'd11:   flip[11] = 1'b1;
      4'd12:   flip[12] = 1'b1;
      default: pos_ok   = 1'b0;
    endcase
    no_error      = (syn == '0) && !ovr;
    corrected     = ovr && pos_ok;
    uncorrectable = !no_error && !corrected;
    r_fix         = corrected ? (r ^ flip) : r;
  end

endmodule

// File: rtl/fuec_encoder_13_8.sv
// Combinational SEC-DED encoder: cw = {data, overall parity, check[3:0]}.
module fuec_encoder_13_8
  import fuec_13_8_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw
);

  logic [PAR_W-2:0] chk;

  // Build the codeword from data and its check bits.
  always_comb begin
    chk = hamming_chk(data);
    cw  = {data, ^{data, chk}, chk};
  end

endmodule

// File: rtl/fuec_scrub_timer.sv
// Scrub interval timer and scrub address counter.
module fuec_scrub_timer #(
  parameter  int unsigned DEPTH          = 16,
  parameter  int unsigned SCRUB_INTERVAL = 256,
  localparam int unsigned ADDR_W         = $clog2(DEPTH),
  localparam int unsigned TMR_W          = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              scrub_start,
  input  logic              scrub_adv,
  output logic              scrub_pend,
  output logic [ADDR_W-1:0] scrub_addr
);

  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Timer tick sets pend (wins over a same-cycle start); disabling holds the timer and drops pend.
  always_comb begin
    tmr_d  = tmr_q;
    pend_d = pend_q;
    addr_d = addr_q;
    if (scrub_start) pend_d = 1'b0;
    if (!scrub_en) begin
      pend_d = 1'b0;
    end else if (tmr_q == TMR_W'(SCRUB_INTERVAL - 1)) begin
      tmr_d  = '0;
      pend_d = 1'b1;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    if (scrub_adv) addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  end

  // Timer, pending flag and address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      pend_q <= 1'b0;
      addr_q <= '0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      addr_q <= addr_d;
    end
  end

  assign scrub_pend = pend_q;
  assign scrub_addr = addr_q;

endmodule

// File: rtl/fuec_scrub_ctrl_13_8.sv
// ECC memory controller: host read/write with SEC-DED correction, writeback and background scrub.
module fuec_scrub_ctrl_13_8
  import fuec_13_8_pkg::*;
#(
  parameter  int unsigned DEPTH          = 16,
  parameter  int unsigned SCRUB_INTERVAL = 256,
  localparam int unsigned ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic [CW_W-1:0]   mem_rdata,
  input  logic              scrub_en,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              host_op_q, host_op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW_W-1:0]   fix_q, fix_d;
  logic [15:0]       corr_q, corr_d;
  logic [15:0]       uncorr_q, uncorr_d;

  logic              scrub_pend, scrub_start, scrub_adv;
  logic [ADDR_W-1:0] scrub_addr;
  logic [CW_W-1:0]   enc_cw, r_fix;
  logic              dec_ok, dec_corr, dec_uncorr;

  fuec_encoder_13_8 u_enc (
    .data (wdata_q),
    .cw   (enc_cw)
  );

  fuec_decoder_13_8 u_dec (
    .r             (mem_rdata),
    .r_fix         (r_fix),
    .no_error      (dec_ok),
    .corrected     (dec_corr),
    .uncorrectable (dec_uncorr)
  );

  fuec_scrub_timer #(
    .DEPTH          (DEPTH),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .scrub_en    (scrub_en),
    .scrub_start (scrub_start),
    .scrub_adv   (scrub_adv),
    .scrub_pend  (scrub_pend),
    .scrub_addr  (scrub_addr)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      host_op_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fix_q     <= '0;
      corr_q    <= '0;
      uncorr_q  <= '0;
    end else begin
      state_q   <= state_d;
      host_op_q <= host_op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      fix_q     <= fix_d;
      corr_q    <= corr_d;
      uncorr_q  <= uncorr_d;
    end
  end

  // Next state: host beats scrub in IDLE; DEC picks writeback or return and bumps counters.
  always_comb begin
    state_d     = state_q;
    host_op_d   = host_op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fix_d       = fix_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    scrub_start = 1'b0;
    scrub_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          host_op_d = 1'b1;
          addr_d    = host_addr;
          wdata_d   = host_wdata;
          state_d   = host_we ? WR : RD;
        end else if (scrub_pend) begin
          host_op_d   = 1'b0;
          addr_d      = scrub_addr;
          scrub_start = 1'b1;
          state_d     = RD;
        end
      end
      RD: state_d = DEC;
      DEC: begin
        fix_d     = r_fix;
        scrub_adv = !host_op_q;
        unique case (1'b1)
          dec_corr: begin
            corr_d  = (corr_q == '1) ? corr_q : corr_q + 16'd1;
            state_d = WB;
          end
          dec_uncorr: begin
            uncorr_d = (uncorr_q == '1) ? uncorr_q : uncorr_q + 16'd1;
            state_d  = IDLE;
          end
          dec_ok:  state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
      WB:      state_d = IDLE;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; everything is forced low while reset is asserted.
  always_comb begin
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    host_err    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: host_gnt = host_req;
        RD: begin
          mem_en   = 1'b1;
          mem_addr = addr_q;
        end
        DEC: begin
          if (host_op_q) begin
            host_rvalid = 1'b1;
            host_rdata  = r_fix[DATA_MSB:DATA_LSB];
            host_err    = dec_uncorr;
          end
        end
        WB: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = fix_q;
        end
        WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = enc_cw;
        end
        default: ;
      endcase
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fuec_scrub_ctrl_13_8.sv
// Bench for fuec_scrub_ctrl_13_8: directed host vectors from a table, then scrub / arbitration / reset sequences.
module tb_fuec_scrub_ctrl_13_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_we;
  logic [3:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt, host_rvalid, host_err;
  logic [7:0]  host_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [12:0] mem_wdata;
  logic [12:0] mem_rdata;
  logic        scrub_en;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic        busy;

  always #5 clk = ~clk;

  fuec_scrub_ctrl_13_8 #(
    .DEPTH          (16),
    .SCRUB_INTERVAL (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .host_err    (host_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .scrub_en    (scrub_en),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt),
    .busy        (busy)
  );

  // Memory model with error injection port and access logging.
  logic [12:0] mem [16];
  logic [12:0] rdata_q = '0;
  logic        inj_en = 1'b0;
  logic [3:0]  inj_addr = '0;
  logic [12:0] inj_mask = '0;
  int          wr_cnt = 0;
  int          rd_n = 0;
  int          rv_cnt = 0;
  logic [3:0]  last_wr_addr = '0;
  logic [12:0] last_wr_data = '0;
  logic [3:0]  rd_log [1024];

  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (inj_en) mem[inj_addr] <= mem[inj_addr] ^ inj_mask;
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_wdata;
    end
    if (mem_en && !mem_we) begin
      rdata_q            <= mem[mem_addr];
      rd_log[rd_n % 1024] <= mem_addr;
      rd_n               <= rd_n + 1;
    end
    if (host_rvalid) rv_cnt <= rv_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // H columns of data bits 0..7, packed 4 bits each.
  localparam logic [31:0] COLS = {4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3};

  function automatic logic [12:0] tb_enc(input logic [7:0] d);
    logic [3:0] c;
    c = '0;
    for (int j = 0; j < 8; j++) if (d[j]) c = c ^ COLS[j*4 +: 4];
    return {d, ^{d, c}, c};
  endfunction

  function automatic logic [7:0] sdat(input int i);
    return 8'((i * 29 + 7) & 255);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},    32'(host_gnt), 0);
    chk({tag, "_rvalid"}, 32'(host_rvalid), 0);
    chk({tag, "_rdata"},  32'(host_rdata), 0);
    chk({tag, "_err"},    32'(host_err), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_maddr"},  32'(mem_addr), 0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 0);
    chk({tag, "_corr"},   32'(corr_cnt), 0);
    chk({tag, "_uncorr"}, 32'(uncorr_cnt), 0);
    chk({tag, "_busy"},   32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; host_req = 1'b0; scrub_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic inject(input logic [3:0] a, input logic [12:0] m);
    @(negedge clk);
    inj_addr = a; inj_mask = m; inj_en = 1'b1;
    @(negedge clk);
    inj_en = 1'b0;
  endtask

  // Issue one host access; checks grant, access cycle at grant+1 and rvalid at grant+2.
  task automatic host_op(input logic we, input logic [3:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic er, output int waits);
    rd = '0; er = 1'b0; waits = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    #1;
    while (!host_gnt && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    chk("grant", 32'(host_gnt), 1);
    @(negedge clk); #1;
    chk("gnt_low_after_grant", 32'(host_gnt), 0);
    host_req = 1'b0;
    chk("acc_mem_en", 32'(mem_en), 1);
    chk("acc_mem_we", 32'(mem_we), 32'(we));
    chk("acc_addr", 32'(mem_addr), 32'(a));
    if (we) begin
      chk("wr_codeword", 32'(mem_wdata), 32'(tb_enc(d)));
    end else begin
      @(negedge clk); #1;
      chk("rvalid_grant_plus2", 32'(host_rvalid), 1);
      rd = host_rdata;
      er = host_err;
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [12:0] flip;
    logic [7:0]  exp_rdata;
    logic        chk_data;
    logic        exp_err;
    logic        exp_wb;
    logic [15:0] exp_corr;
    logic [15:0] exp_uncorr;
  } vec_t;

  vec_t        vecs [12];
  logic [7:0]  rd;
  logic        er;
  int          waits, wr0, rv0, rd0, rd1, n;
  logic [12:0] m;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //             we    addr   wdata  flip      exp_rd  chkd  err   wb    corr   uncorr
    vecs[0]  = '{1'b1, 4'd3,  8'hAC, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, 13'h0000, 8'hAC, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 4'd3,  8'h00, 13'h0080, 8'hAC, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
    vecs[3]  = '{1'b0, 4'd3,  8'h00, 13'h0000, 8'hAC, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[4]  = '{1'b1, 4'd5,  8'h5A, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    vecs[5]  = '{1'b0, 4'd5,  8'h00, 13'h0003, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1};
    vecs[6]  = '{1'b1, 4'd0,  8'h00, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[7]  = '{1'b0, 4'd0,  8'h00, 13'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[8]  = '{1'b1, 4'd15, 8'hFF, 13'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[9]  = '{1'b0, 4'd15, 8'h00, 13'h1000, 8'hFF, 1'b1, 1'b0, 1'b1, 16'd2, 16'd1};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 13'h0010, 8'h00, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1};
    vecs[11] = '{1'b0, 4'd15, 8'h00, 13'h1020, 8'h00, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};

    // Reset with a request pending: everything must read zero.
    rst_n = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0; scrub_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    host_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed host vectors.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].flip != '0) inject(vecs[i].addr, vecs[i].flip);
      @(negedge clk);
      wr0 = wr_cnt; rv0 = rv_cnt;
      host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, waits);
      repeat (3) @(negedge clk);
      if (vecs[i].we) begin
        chk("wr_mem", 32'(mem[vecs[i].addr]), 32'(tb_enc(vecs[i].wdata)));
        chk("wr_count", 32'(wr_cnt - wr0), 1);
      end else begin
        if (vecs[i].chk_data) chk("rdata", 32'(rd), 32'(vecs[i].exp_rdata));
        chk("err", 32'(er), 32'(vecs[i].exp_err));
        chk("wb_count", 32'(wr_cnt - wr0), 32'(vecs[i].exp_wb));
        if (vecs[i].exp_wb) begin
          chk("wb_addr", 32'(last_wr_addr), 32'(vecs[i].addr));
          chk("wb_data", 32'(last_wr_data), 32'(tb_enc(vecs[i].exp_rdata)));
        end
        chk("rvalid_once", 32'(rv_cnt - rv0), 1);
      end
      chk("corr_cnt", 32'(corr_cnt), 32'(vecs[i].exp_corr));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(vecs[i].exp_uncorr));
    end

    // Background scrub over all 16 words, each with one flipped bit.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 16; i++) host_op(1'b1, 4'(i), sdat(i), rd, er, waits);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      m = '0;
      m[i % 13] = 1'b1;
      inject(4'(i), m);
    end
    rd0 = rd_n; rv0 = rv_cnt; wr0 = wr_cnt;
    scrub_en = 1'b1;
    n = 0;
    while ((rd_n - rd0) < 17 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    scrub_en = 1'b0;
    chk("scrub_reads_seen", 32'(((rd_n - rd0) >= 17) ? 1 : 0), 1);
    for (int k = 0; k < 17; k++) chk("scrub_addr_seq", 32'(rd_log[(rd0 + k) % 1024]), 32'(k % 16));
    repeat (4) @(negedge clk);
    chk("scrub_corr_cnt", 32'(corr_cnt), 16);
    chk("scrub_uncorr_cnt", 32'(uncorr_cnt), 0);
    chk("scrub_wb_count", 32'(wr_cnt - wr0), 16);
    chk("scrub_no_rvalid", 32'(rv_cnt - rv0), 0);
    for (int i = 0; i < 16; i++) chk("scrub_mem_fixed", 32'(mem[i]), 32'(tb_enc(sdat(i))));
    rd1 = rd_n;
    repeat (20) @(negedge clk);
    chk("scrub_disabled_idle", 32'(rd_n - rd1), 0);

    // Host request in the first cycle scrub_pend is set: host first, scrub right after.
    do_reset();
    scrub_en = 1'b1;
    rd0 = rd_n;
    repeat (4) @(negedge clk);
    host_op(1'b0, 4'd9, 8'h00, rd, er, waits);
    chk("arb_host_no_wait", 32'(waits), 0);
    chk("arb_rdata", 32'(rd), 32'(sdat(9)));
    chk("arb_err", 32'(er), 0);
    chk("arb_first_read", 32'(rd_log[rd0 % 1024]), 9);
    n = 0;
    while ((rd_n - rd0) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("arb_scrub_follows", 32'(((rd_n - rd0) >= 2) ? 1 : 0), 1);
    chk("arb_scrub_addr", 32'(rd_log[(rd0 + 1) % 1024]), 0);
    scrub_en = 1'b0;
    repeat (4) @(negedge clk);

    // Reset asserted during the writeback cycle.
    host_op(1'b1, 4'd3, 8'hC5, rd, er, waits);
    repeat (3) @(negedge clk);
    inject(4'd3, 13'h0200);
    @(negedge clk);
    host_op(1'b0, 4'd3, 8'h00, rd, er, waits);
    chk("rstwb_rdata", 32'(rd), 32'hC5);
    wr0 = wr_cnt;
    @(negedge clk); #1;
    chk("rstwb_in_wb_en", 32'(mem_en), 1);
    chk("rstwb_in_wb_we", 32'(mem_we), 1);
    chk("rstwb_busy", 32'(busy), 1);
    chk("rstwb_corr_before", 32'(corr_cnt), 1);
    rst_n = 1'b0;
    #1;
    chk("rstwb_mem_en_gated", 32'(mem_en), 0);
    @(negedge clk); #1;
    chk("rstwb_no_write", 32'(wr_cnt - wr0), 0);
    chk("rstwb_mem_kept", 32'(mem[3]), 32'(tb_enc(8'hC5) ^ 13'h0200));
    check_zero("rstwb");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
